wb_stage_mlane: RTL and testbench

- Multi-lane writeback stage; parametrised successor to the single-lane writeback pipeline register.
- Sits between MEM and the register file / HI-LO unit.
- Latches up to LANES retiring instructions per cycle and commits their RF writes exactly once.
- Holds the architectural HI/LO registers, and serialises all retirements onto the single-lane debug trace port through an internal FIFO, raising a stall request when that FIFO would overflow.

---
 rtl/wb_stage_mlane.sv | 241 ++++++++++++++++++++++++
 tb/tb_wb_stage_mlane.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_mlane.sv
// Multi-lane writeback stage: stage register, RF commit, HI/LO and a serialised debug trace FIFO.
// Optional macro WB_HILO_EN: when defined, the HI/LO registers and their update logic are built.

module wb_stage_mlane #(
    parameter int LANES     = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DBG_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_pc,
    input  logic [LANES-1:0]        in_we,
    input  logic [LANES*ADDR_W-1:0] in_waddr,
    input  logic [LANES*DATA_W-1:0] in_wdata,
    input  logic [LANES-1:0]        in_hi_we,
    input  logic [LANES-1:0]        in_lo_we,
    input  logic [LANES*DATA_W-1:0] in_hi,
    input  logic [LANES*DATA_W-1:0] in_lo,
    output logic [LANES-1:0]        rf_we,
    output logic [LANES*ADDR_W-1:0] rf_waddr,
    output logic [LANES*DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0]       hi_o,
    output logic [DATA_W-1:0]       lo_o,
    output logic                    stallreq_wb,
    output logic [31:0]             debug_wb_pc,
    output logic [3:0]              debug_wb_rf_wen,
    output logic [4:0]              debug_wb_rf_wnum,
    output logic [31:0]             debug_wb_rf_wdata
);

    localparam int PW = $clog2(DBG_DEPTH);
    localparam int CW = PW + 2;
    localparam int EW = 2*DATA_W + 1 + ADDR_W;

    logic [LANES-1:0]        st_valid_q, st_valid_d, st_we_q, st_we_d;
    logic [LANES*DATA_W-1:0] st_pc_q, st_pc_d, st_wdata_q, st_wdata_d;
    logic [LANES*ADDR_W-1:0] st_waddr_q, st_waddr_d;
    logic                    fresh_q, fresh_d;
    logic                    hold_s;

    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]             count_q, count_d;
    logic [CW-1:0]           pushes_s, next_level_s;
    logic [LANES-1:0]        push_en_s;
    logic [PW-1:0]           push_idx_s [LANES];
    logic [EW-1:0]           entry_s [LANES];
    logic [EW-1:0]           fifo_mem [DBG_DEPTH];
    logic [EW-1:0]           head_s;
    logic                    pop_s;

    logic [31:0]             dbg_pc_q, dbg_pc_d, dbg_wdata_q, dbg_wdata_d;
    logic [3:0]              dbg_wen_q, dbg_wen_d;
    logic [4:0]              dbg_wnum_q, dbg_wnum_d;

    // Pushes this cycle: every valid lane of a fresh entry, packed in ascending lane order.
    always_comb begin
        pushes_s = '0;
        for (int i = 0; i < LANES; i++) begin
            push_en_s[i]  = st_valid_q[i] & fresh_q;
            push_idx_s[i] = wr_ptr_q + pushes_s[PW-1:0];
            entry_s[i]    = {st_pc_q[i*DATA_W +: DATA_W], st_we_q[i],
                             st_waddr_q[i*ADDR_W +: ADDR_W], st_wdata_q[i*DATA_W +: DATA_W]};
            pushes_s      = pushes_s + CW'(push_en_s[i]);
        end
        stallreq_wb = ({1'b0, count_q} + pushes_s) > CW'(DBG_DEPTH - LANES);
        hold_s      = stall | stallreq_wb;
    end

    // Stage register next state; fresh lasts exactly one cycle per loaded entry.
    always_comb begin
        if (flush) begin
            st_valid_d = '0;
            st_we_d    = '0;
            st_pc_d    = '0;
            st_waddr_d = '0;
            st_wdata_d = '0;
            fresh_d    = 1'b0;
        end else if (hold_s) begin
            st_valid_d = st_valid_q;
            st_we_d    = st_we_q;
            st_pc_d    = st_pc_q;
            st_waddr_d = st_waddr_q;
            st_wdata_d = st_wdata_q;
            fresh_d    = 1'b0;
        end else begin
            st_valid_d = in_valid;
            st_we_d    = in_we;
            st_pc_d    = in_pc;
            st_waddr_d = in_waddr;
            st_wdata_d = in_wdata;
            fresh_d    = |in_valid;
        end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_valid_q <= '0;
            st_we_q    <= '0;
            st_pc_q    <= '0;
            st_waddr_q <= '0;
            st_wdata_q <= '0;
            fresh_q    <= 1'b0;
        end else begin
            st_valid_q <= st_valid_d;
            st_we_q    <= st_we_d;
            st_pc_q    <= st_pc_d;
            st_waddr_q <= st_waddr_d;
            st_wdata_q <= st_wdata_d;
            fresh_q    <= fresh_d;
        end
    end

    assign rf_we    = st_valid_q & st_we_q & {LANES{fresh_q}};
    assign rf_waddr = st_waddr_q;
    assign rf_wdata = st_wdata_q;

    // FIFO pointer/count update and head unpacking into the debug registers.
    always_comb begin
        pop_s    = (count_q != '0);
        head_s   = fifo_mem[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PW'(pop_s);
        wr_ptr_d = wr_ptr_q + pushes_s[PW-1:0];
        count_d  = count_q + pushes_s[PW:0] - (PW+1)'(pop_s);
        if (pop_s) begin
            dbg_pc_d    = 32'(head_s[EW-1 -: DATA_W]);
            dbg_wen_d   = {4{head_s[DATA_W+ADDR_W]}};
            dbg_wnum_d  = 5'(head_s[DATA_W +: ADDR_W]);
            dbg_wdata_d = 32'(head_s[DATA_W-1:0]);
        end else begin
            dbg_pc_d    = 32'd0;
            dbg_wen_d   = 4'd0;
            dbg_wnum_d  = 5'd0;
            dbg_wdata_d = 32'd0;
        end
    end

    // Trace storage; entries are only read below count, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_en_s[i]) begin
                fifo_mem[push_idx_s[i]] <= entry_s[i];
            end
        end
    end

    // FIFO control and registered debug outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dbg_pc_q    <= 32'd0;
            dbg_wen_q   <= 4'd0;
            dbg_wnum_q  <= 5'd0;
            dbg_wdata_q <= 32'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dbg_pc_q    <= dbg_pc_d;
            dbg_wen_q   <= dbg_wen_d;
            dbg_wnum_q  <= dbg_wnum_d;
            dbg_wdata_q <= dbg_wdata_d;
        end
    end

    assign debug_wb_pc       = dbg_pc_q;
    assign debug_wb_rf_wen   = dbg_wen_q;
    assign debug_wb_rf_wnum  = dbg_wnum_q;
    assign debug_wb_rf_wdata = dbg_wdata_q;

`ifdef WB_HILO_EN
    logic [LANES-1:0]        st_hi_we_q, st_hi_we_d, st_lo_we_q, st_lo_we_d;
    logic [LANES*DATA_W-1:0] st_hi_q, st_hi_d, st_lo_q, st_lo_d;
    logic [DATA_W-1:0]       hi_q, hi_d, lo_q, lo_d;

    // HI/LO stage fields follow the stage register; highest committing lane wins.
    always_comb begin
        if (flush) begin
            st_hi_we_d = '0;
            st_lo_we_d = '0;
            st_hi_d    = '0;
            st_lo_d    = '0;
        end else if (hold_s) begin
            st_hi_we_d = st_hi_we_q;
            st_lo_we_d = st_lo_we_q;
            st_hi_d    = st_hi_q;
            st_lo_d    = st_lo_q;
        end else begin
            st_hi_we_d = in_hi_we;
            st_lo_we_d = in_lo_we;
            st_hi_d    = in_hi;
            st_lo_d    = in_lo;
        end
        hi_d = hi_q;
        lo_d = lo_q;
        for (int i = 0; i < LANES; i++) begin
            hi_d = (fresh_q & st_valid_q[i] & st_hi_we_q[i]) ? st_hi_q[i*DATA_W +: DATA_W] : hi_d;
            lo_d = (fresh_q & st_valid_q[i] & st_lo_we_q[i]) ? st_lo_q[i*DATA_W +: DATA_W] : lo_d;
        end
    end

    // HI/LO registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_hi_we_q <= '0;
            st_lo_we_q <= '0;
            st_hi_q    <= '0;
            st_lo_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            st_hi_we_q <= st_hi_we_d;
            st_lo_we_q <= st_lo_we_d;
            st_hi_q    <= st_hi_d;
            st_lo_q    <= st_lo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
`else
    logic unused_hilo_s;
    assign unused_hilo_s = ^{in_hi_we, in_lo_we, in_hi, in_lo};
    assign hi_o = '0;
    assign lo_o = '0;
`endif

    assign next_level_s = {1'b0, count_q} + pushes_s - CW'(pop_s);

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        next_level_s <= CW'(DBG_DEPTH));

endmodule

// File: tb/tb_wb_stage_mlane.sv
// Directed self-checking bench for wb_stage_mlane (LANES=2, DBG_DEPTH=8).
module tb_wb_stage_mlane;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  in_valid, in_we, in_hi_we, in_lo_we;
    logic [63:0] in_pc, in_wdata, in_hi, in_lo;
    logic [9:0]  in_waddr;
    logic [1:0]  rf_we;
    logic [9:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_wb;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage_mlane #(.LANES(2), .DATA_W(32), .ADDR_W(5), .DBG_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_we(in_we), .in_waddr(in_waddr),
        .in_wdata(in_wdata), .in_hi_we(in_hi_we), .in_lo_we(in_lo_we),
        .in_hi(in_hi), .in_lo(in_lo),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hi_o(hi_o), .lo_o(lo_o), .stallreq_wb(stallreq_wb),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [31:0] pc0, input logic [4:0] a0, input logic [4:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1);
        in_valid = 2'b11;
        in_we    = 2'b11;
        in_pc    = {pc0 + 32'd4, pc0};
        in_waddr = {a1, a0};
        in_wdata = {d1, d0};
    endtask

    task automatic idle();
        in_valid = 2'b00;
        in_we    = 2'b00;
        in_hi_we = 2'b00;
        in_lo_we = 2'b00;
    endtask

    initial begin
        int traces;
        int got;
        int n_ld;
        int tb_cnt;
        int tb_pend;
        logic sr;
        logic seen_sr;
        logic [31:0] exp_pc;

        idle();
        in_pc = 64'd0; in_wdata = 64'd0; in_waddr = 10'd0; in_hi = 64'd0; in_lo = 64'd0;
        #2;
        check_val("rst_rf_we", rf_we, 2'b00);
        check_val("rst_stallreq", stallreq_wb, 1'b0);
        check_val("rst_dbg_wen", debug_wb_rf_wen, 4'h0);
        check_val("rst_dbg_pc", debug_wb_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single dual-lane load and its trace latency.
        set_lanes(32'hBFC00000, 5'd3, 5'd4, 32'h11, 32'h22);
        tick();
        check_val("t2_rf_we_E0", rf_we, 2'b11);
        check_val("t2_rf_waddr", rf_waddr, {5'd4, 5'd3});
        check_val("t2_rf_wdata", rf_wdata, {32'h22, 32'h11});
        idle();
        tick();
        check_val("t2_rf_we_E1", rf_we, 2'b00);
        check_val("t2_wen_E1", debug_wb_rf_wen, 4'h0);
        tick();
        check_val("t2_pc_E2", debug_wb_pc, 32'hBFC00000);
        check_val("t2_wen_E2", debug_wb_rf_wen, 4'hF);
        check_val("t2_wnum_E2", debug_wb_rf_wnum, 5'd3);
        check_val("t2_wdata_E2", debug_wb_rf_wdata, 32'h11);
        tick();
        check_val("t2_pc_E3", debug_wb_pc, 32'hBFC00004);
        check_val("t2_wnum_E3", debug_wb_rf_wnum, 5'd4);
        check_val("t2_wdata_E3", debug_wb_rf_wdata, 32'h22);
        tick();
        check_val("t2_wen_E4", debug_wb_rf_wen, 4'h0);

        // Stall held for 5 cycles after a load: one RF pulse, two trace entries.
        set_lanes(32'hBFC00100, 5'd5, 5'd6, 32'h33, 32'h44);
        tick();
        check_val("t3_rf_we_E0", rf_we, 2'b11);
        stall = 1'b1;
        set_lanes(32'hBFC00200, 5'd7, 5'd8, 32'h55, 32'h66);
        traces = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_val("t3_rf_we_hold", rf_we, 2'b00);
            if (debug_wb_rf_wen == 4'hF) traces++;
        end
        check_val("t3_waddr_held", rf_waddr, {5'd6, 5'd5});
        check_val("t3_trace_cnt", traces, 2);
        idle();
        stall = 1'b0;
        tick();
        check_val("t3_rf_we_after", rf_we, 2'b00);
        tick();

        // Flush together with stall on a fresh entry.
        set_lanes(32'hBFC00300, 5'd9, 5'd10, 32'h77, 32'h88);
        tick();
        flush = 1'b1;
        stall = 1'b1;
        #1;
        check_val("t6_commit", rf_we, 2'b11);
        tick();
        check_val("t6_rf_we_E1", rf_we, 2'b00);
        check_val("t6_waddr_clr", rf_waddr, 10'd0);
        check_val("t6_wdata_clr", rf_wdata, 64'd0);
        flush = 1'b0;
        stall = 1'b0;
        idle();
        tick();
        check_val("t6_rf_we_E2", rf_we, 2'b00);
        check_val("t6_pc_E2", debug_wb_pc, 32'hBFC00300);
        check_val("t6_wnum_E2", debug_wb_rf_wnum, 5'd9);
        tick();
        check_val("t6_pc_E3", debug_wb_pc, 32'hBFC00304);
        tick();
        check_val("t6_wen_E4", debug_wb_rf_wen, 4'h0);

        // HI/LO: highest lane with a write enable wins.
        set_lanes(32'hBFC00400, 5'd1, 5'd2, 32'h0, 32'h0);
        in_hi_we = 2'b11;
        in_hi    = {32'h0000BBBB, 32'h0000AAAA};
        in_lo_we = 2'b01;
        in_lo    = {32'h00009999, 32'h00001234};
        tick();
        check_val("t5_hi_before", hi_o, 32'h0);
        idle();
        tick();
`ifdef WB_HILO_EN
        check_val("t5_hi_after", hi_o, 32'h0000BBBB);
        check_val("t5_lo_after", lo_o, 32'h00001234);
`else
        check_val("t5_hi_after", hi_o, 32'h0);
        check_val("t5_lo_after", lo_o, 32'h0);
`endif
        tick();
        tick();
        tick();

        // Back-to-back dual-lane loads: backpressure and trace ordering.
        exp_pc  = 32'hBFC00000;
        got     = 0;
        n_ld    = 0;
        tb_cnt  = 0;
        tb_pend = 0;
        seen_sr = 1'b0;
        for (int c = 0; c < 80 && got < 20; c++) begin
            if (n_ld < 10) set_lanes(32'hBFC00000 + 32'(n_ld * 8), 5'd1, 5'd2, 32'(n_ld), 32'(n_ld));
            else idle();
            #1;
            sr = stallreq_wb;
            check_val("t4_stallreq", sr, (tb_cnt + tb_pend > 6) ? 1'b1 : 1'b0);
            if (sr) seen_sr = 1'b1;
            tick();
            tb_cnt  = tb_cnt + tb_pend - ((tb_cnt > 0) ? 1 : 0);
            tb_pend = (!sr && n_ld < 10) ? 2 : 0;
            if (!sr && n_ld < 10) n_ld++;
            if (debug_wb_rf_wen == 4'hF) begin
                check_val("t4_trace_pc", debug_wb_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
        end
        check_val("t4_trace_total", got, 20);
        check_val("t4_stallreq_seen", seen_sr, 1'b1);
        check_val("t4_stallreq_end", stallreq_wb, 1'b0);
        tick();
        tick();

        // Asynchronous reset mid-stream with two entries queued.
        set_lanes(32'hBFC01000, 5'd11, 5'd12, 32'h1, 32'h2);
        tick();
        set_lanes(32'hBFC01008, 5'd13, 5'd14, 32'h3, 32'h4);
        tick();
        idle();
        check_val("t1_pre_rf_we", rf_we, 2'b11);
        #2;
        rst = 1'b0;
        #1;
        check_val("t1_rf_we", rf_we, 2'b00);
        check_val("t1_stallreq", stallreq_wb, 1'b0);
        check_val("t1_wen", debug_wb_rf_wen, 4'h0);
        check_val("t1_pc", debug_wb_pc, 32'h0);
        check_val("t1_hi", hi_o, 32'h0);
        check_val("t1_lo", lo_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("t1_no_trace", debug_wb_rf_wen, 4'h0);
            check_val("t1_no_write", rf_we, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end
endmodule
